// File: rtl/charrua_apb_pkg.sv
// Shared APB definitions for the charrua general-memory APB slave.
// Contents:
//   - apb_state_t       : slave FSM states (IDLE, ACCESS)
//   - APB_DATA_W/ADDR_W : APB data and address bus widths
//   - PPROT_*           : PPROT bit indices, reserved for future protection checks
//   - addr_in_range()   : true when no address bit at or above abits is set
package charrua_apb_pkg;

    localparam int APB_DATA_W = 16;
    localparam int APB_ADDR_W = 16;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    function automatic logic addr_in_range(input logic [APB_ADDR_W-1:0] addr,
                                           input int abits);
        return (addr >> abits) == '0;
    endfunction

endpackage

// File: rtl/spram.sv
// Single-port synchronous RAM with registered read.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable, word written at addr on this edge
//   addr  : word address shared by read and write
//   wdata : write data
//   rdata : registered read data; read-first, so a write edge returns the old word
// Contents are not initialised and are never reset.
module spram #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/apb_gen_mem_slave.sv
// APB3 slave memory for the core's general-memory APB master port.
// Holds 16-bit words in a single-port RAM, inserts WAIT_STATES extra access
// cycles before PREADY, and silently discards out-of-range accesses
// (reads return 16'h0000, writes are dropped).
// Ports:
//   CLOCK, RESET     : clock and synchronous active-high reset
//   PADDR, PPROT     : word address; protection attributes (accepted, unused)
//   PSEL, PENABLE    : APB select and access-phase strobe
//   PWRITE, PWDATA   : direction and write data, captured at the setup edge
//   PRDATA, PREADY   : read data and transfer-complete strobe (register-decoded)
//   dbg_state_o      : current FSM state (0 = IDLE, 1 = ACCESS)
// Handshake: a transfer starts with the edge that sees PSEL=1 in IDLE (setup);
// it completes on the first edge in ACCESS with PSEL=1, PENABLE=1 and PREADY=1.
// Dropping PSEL in ACCESS aborts the transfer without writing.
module apb_gen_mem_slave
    import charrua_apb_pkg::*;
#(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 0,
    parameter int DATA_BITS   = 16
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] PADDR,
    input  logic [2:0]  PPROT,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [15:0] PWDATA,
    output logic [15:0] PRDATA,
    output logic        PREADY,
    output logic        dbg_state_o
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    apb_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic                  in_range_q, in_range_d;
    // live_q: the RAM output register holds this transfer's read word right now.
    // After one cycle the word is copied into hold_q so PRDATA stays stable
    // until the next setup edge, even after a write changes the RAM.
    logic                  live_q, live_d;
    logic [APB_DATA_W-1:0] hold_q, hold_d;

    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_addr;
    logic [DATA_BITS-1:0]  ram_rdata;
    logic [APB_DATA_W-1:0] rd_word;

    logic                  unused_pprot;
    assign unused_pprot = ^PPROT;

    spram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_ram (
        .clk   (CLOCK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (pwdata_q),
        .rdata (ram_rdata)
    );

    assign rd_word = in_range_q ? ram_rdata : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        in_range_d = in_range_q;
        live_d     = 1'b0;
        hold_d     = live_q ? rd_word : hold_q;
        ram_we     = 1'b0;
        ram_addr   = addr_q;

        case (state_q)
            IDLE: begin
                // PENABLE is ignored here: a missing setup phase is simply
                // treated as the setup cycle.
                if (PSEL) begin
                    state_d    = ACCESS;
                    cnt_d      = WS_INIT;
                    addr_d     = PADDR[ADDR_BITS-1:0];
                    pwrite_d   = PWRITE;
                    pwdata_d   = PWDATA;
                    in_range_d = addr_in_range(PADDR, ADDR_BITS);
                    ram_addr   = PADDR[ADDR_BITS-1:0];
                    live_d     = 1'b1;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        // Reset on the completion edge wins: no write.
                        ram_we  = pwrite_q && in_range_q && !RESET;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            in_range_q <= 1'b0;
            live_q     <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            in_range_q <= in_range_d;
            live_q     <= live_d;
            hold_q     <= hold_d;
        end
    end

    assign PRDATA      = live_q ? rd_word : hold_q;
    assign PREADY      = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign dbg_state_o = state_q;

endmodule
